// File: rtl/fetch_line_buffer.sv
// Direct-mapped line buffer between a CPU fetch/load port and a line-wide RAM.
// Hits answer one cycle after acceptance; misses fetch a full line, fill it, then answer.
module fetch_line_buffer #(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int ENTRIES    = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         cpu_req_valid,
    input  logic [ADDR_W-1:0]            cpu_req_addr,
    output logic                         cpu_req_ready,
    output logic                         cpu_rsp_valid,
    output logic [WORD_W-1:0]            cpu_rsp_data,
    input  logic                         flush,
    output logic                         ram_req_valid,
    output logic [ADDR_W-1:0]            ram_req_addr,
    input  logic                         ram_req_ready,
    input  logic                         ram_rsp_valid,
    input  logic [WORD_W*LINE_WORDS-1:0] ram_rsp_data,
    output logic [15:0]                  hit_count,
    output logic [15:0]                  miss_count,
    output logic [1:0]                   dbg_state
);

    // Handshakes: a transfer happens on the rising edge where valid && ready;
    // a raised valid keeps its payload stable until that edge.

    localparam int BO     = $clog2(WORD_W / 8);
    localparam int WO     = $clog2(LINE_WORDS);
    localparam int IX     = $clog2(ENTRIES);
    localparam int IXW    = (IX > 0) ? IX : 1;
    localparam int TAG_W  = ADDR_W - BO - WO - IX;
    localparam int LINE_W = WORD_W * LINE_WORDS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    function automatic logic [IXW-1:0] idx_of(input logic [ADDR_W-1:0] a);
        if (IX == 0) return '0;
        return IXW'(a >> (BO + WO));
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
        return TAG_W'(a >> (BO + WO + IX));
    endfunction

    function automatic logic [WO-1:0] off_of(input logic [ADDR_W-1:0] a);
        return WO'(a >> BO);
    endfunction

    function automatic logic [ADDR_W-1:0] line_addr_of(input logic [ADDR_W-1:0] a);
        return (a >> (BO + WO)) << (BO + WO);
    endfunction

    function automatic logic [WORD_W-1:0] sel_word(input logic [LINE_W-1:0] line,
                                                   input logic [WO-1:0]     off);
        return line[int'(off)*WORD_W +: WORD_W];
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Storage arrays; only the valid bits carry reset state.
    logic [LINE_W-1:0]  data_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [ENTRIES-1:0] valid_q, valid_d;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                flush_pending_q, flush_pending_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [WORD_W-1:0]   rsp_data_q, rsp_data_d;
    logic                ram_req_valid_q, ram_req_valid_d;
    logic [ADDR_W-1:0]   ram_req_addr_q, ram_req_addr_d;
    logic [15:0]         hit_cnt_q, hit_cnt_d;
    logic [15:0]         miss_cnt_q, miss_cnt_d;
    logic                fill_we;

    logic [IXW-1:0]   req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [WO-1:0]    req_off;
    logic             req_hit;
    logic [IXW-1:0]   fill_idx;

    assign req_idx  = idx_of(cpu_req_addr);
    assign req_tag  = tag_of(cpu_req_addr);
    assign req_off  = off_of(cpu_req_addr);
    assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign fill_idx = idx_of(addr_q);

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        flush_pending_d = flush_pending_q;
        rsp_valid_d     = 1'b0;
        rsp_data_d      = rsp_data_q;
        ram_req_valid_d = ram_req_valid_q;
        ram_req_addr_d  = ram_req_addr_q;
        hit_cnt_d       = hit_cnt_q;
        miss_cnt_d      = miss_cnt_q;
        valid_d         = valid_q;
        fill_we         = 1'b0;
        cpu_req_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                cpu_req_ready = !flush && !flush_pending_q;
                // A deferred flush takes effect here, so the just-filled line is dropped too.
                if (flush || flush_pending_q) begin
                    valid_d         = '0;
                    flush_pending_d = 1'b0;
                end else if (cpu_req_valid) begin
                    if (req_hit) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = sel_word(data_q[req_idx], req_off);
                        hit_cnt_d   = sat_inc(hit_cnt_q);
                    end else begin
                        addr_d          = cpu_req_addr;
                        miss_cnt_d      = sat_inc(miss_cnt_q);
                        ram_req_valid_d = 1'b1;
                        ram_req_addr_d  = line_addr_of(cpu_req_addr);
                        state_d         = REQ;
                    end
                end
            end
            REQ: begin
                if (flush) flush_pending_d = 1'b1;
                if (ram_req_ready) begin
                    ram_req_valid_d = 1'b0;
                    state_d         = WAIT;
                end
            end
            WAIT: begin
                if (flush) flush_pending_d = 1'b1;
                if (ram_rsp_valid) begin
                    fill_we           = 1'b1;
                    valid_d[fill_idx] = 1'b1;
                    rsp_valid_d       = 1'b1;
                    rsp_data_d        = sel_word(ram_rsp_data, off_of(addr_q));
                    state_d           = RESP;
                end
            end
            RESP: begin
                if (flush) flush_pending_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            flush_pending_q <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            ram_req_valid_q <= 1'b0;
            ram_req_addr_q  <= '0;
            hit_cnt_q       <= '0;
            miss_cnt_q      <= '0;
            valid_q         <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            flush_pending_q <= flush_pending_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            ram_req_valid_q <= ram_req_valid_d;
            ram_req_addr_q  <= ram_req_addr_d;
            hit_cnt_q       <= hit_cnt_d;
            miss_cnt_q      <= miss_cnt_d;
            valid_q         <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_q[fill_idx] <= ram_rsp_data;
            tag_q[fill_idx]  <= tag_of(addr_q);
        end
    end

    assign cpu_rsp_valid = rsp_valid_q;
    assign cpu_rsp_data  = rsp_data_q;
    assign ram_req_valid = ram_req_valid_q;
    assign ram_req_addr  = ram_req_addr_q;
    assign hit_count     = hit_cnt_q;
    assign miss_count    = miss_cnt_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Directed bench for fetch_line_buffer: a table of request vectors plus hand-written
// sequences for back-to-back hits, RAM backpressure, flush and mid-miss reset.
module tb_fetch_line_buffer;

    logic         clk;
    logic         rstn;
    logic         cpu_req_valid;
    logic [31:0]  cpu_req_addr;
    logic         cpu_req_ready;
    logic         cpu_rsp_valid;
    logic [31:0]  cpu_rsp_data;
    logic         flush;
    logic         ram_req_valid;
    logic [31:0]  ram_req_addr;
    logic         ram_req_ready;
    logic         ram_rsp_valid;
    logic [127:0] ram_rsp_data;
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
    logic [1:0]   dbg_state;

    fetch_line_buffer #(
        .ADDR_W(32), .WORD_W(32), .LINE_WORDS(4), .ENTRIES(4)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .cpu_req_valid(cpu_req_valid),
        .cpu_req_addr (cpu_req_addr),
        .cpu_req_ready(cpu_req_ready),
        .cpu_rsp_valid(cpu_rsp_valid),
        .cpu_rsp_data (cpu_rsp_data),
        .flush        (flush),
        .ram_req_valid(ram_req_valid),
        .ram_req_addr (ram_req_addr),
        .ram_req_ready(ram_req_ready),
        .ram_rsp_valid(ram_rsp_valid),
        .ram_rsp_data (ram_rsp_data),
        .hit_count    (hit_count),
        .miss_count   (miss_count),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int ram_accepts = 0;

    always @(posedge clk) begin
        if (rstn && ram_req_valid && ram_req_ready) ram_accepts++;
    end

    localparam logic [127:0] L1 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [127:0] L2 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] L3 = 128'h00000004_00000003_00000002_00000001;
    localparam logic [127:0] L4 = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    localparam logic [127:0] L5 = 128'h53535353_52525252_51515151_50505050;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] line;
        bit           hit;
        logic [31:0]  ram_addr;
        logic [31:0]  data;
        logic [15:0]  hits;
        logic [15:0]  misses;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input string name, input logic [31:0] addr, input logic [127:0] line,
                          input bit exp_hit, input logic [31:0] exp_ram_addr,
                          input logic [31:0] exp_data);
        int acc0;
        acc0 = ram_accepts;
        cpu_req_valid = 1'b1;
        cpu_req_addr  = addr;
        #1;
        chk({name, " ready"}, 32'(cpu_req_ready), 32'd1);
        step();
        cpu_req_valid = 1'b0;
        cpu_req_addr  = 32'hDEAD_BEEF;
        if (exp_hit) begin
            chk({name, " hit rsp_valid"}, 32'(cpu_rsp_valid), 32'd1);
            chk({name, " hit data"}, cpu_rsp_data, exp_data);
            chk({name, " hit no ram req"}, 32'(ram_req_valid), 32'd0);
            step();
        end else begin
            chk({name, " ram_req_valid"}, 32'(ram_req_valid), 32'd1);
            chk({name, " ram_req_addr"}, ram_req_addr, exp_ram_addr);
            chk({name, " no early rsp"}, 32'(cpu_rsp_valid), 32'd0);
            ram_req_ready = 1'b1;
            step();
            ram_req_ready = 1'b0;
            ram_rsp_valid = 1'b1;
            ram_rsp_data  = line;
            step();
            ram_rsp_valid = 1'b0;
            chk({name, " miss rsp_valid"}, 32'(cpu_rsp_valid), 32'd1);
            chk({name, " miss data"}, cpu_rsp_data, exp_data);
            step();
        end
        chk({name, " rsp pulse ends"}, 32'(cpu_rsp_valid), 32'd0);
        chk({name, " ram accepts"}, 32'(ram_accepts - acc0), exp_hit ? 32'd0 : 32'd1);
    endtask

    task automatic run_vec(input int i);
        string nm;
        nm = $sformatf("vec%0d", i);
        do_req(nm, vecs[i].addr, vecs[i].line, vecs[i].hit, vecs[i].ram_addr, vecs[i].data);
        chk({nm, " hit_count"}, 32'(hit_count), 32'(vecs[i].hits));
        chk({nm, " miss_count"}, 32'(miss_count), 32'(vecs[i].misses));
    endtask

    initial begin
        int acc0;
        vecs[0] = '{32'h0000_0104, L1, 1'b0, 32'h0000_0100, 32'hBBBBBBBB, 16'd0, 16'd1};
        vecs[1] = '{32'h0000_0140, L2, 1'b0, 32'h0000_0140, 32'h11111111, 16'd2, 16'd2};
        vecs[2] = '{32'h0000_0104, L1, 1'b0, 32'h0000_0100, 32'hBBBBBBBB, 16'd2, 16'd3};
        vecs[3] = '{32'h0000_0118, L3, 1'b0, 32'h0000_0110, 32'h00000003, 16'd2, 16'd4};
        vecs[4] = '{32'h0000_0114, '0,  1'b1, 32'h0,        32'h00000002, 16'd3, 16'd4};
        vecs[5] = '{32'h0000_0108, '0,  1'b1, 32'h0,        32'hCCCCCCCC, 16'd4, 16'd4};

        rstn = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_req_addr = '0;
        flush = 1'b0;
        ram_req_ready = 1'b0;
        ram_rsp_valid = 1'b0;
        ram_rsp_data = '0;
        repeat (2) step();
        chk("reset rsp_valid", 32'(cpu_rsp_valid), 32'd0);
        chk("reset rsp_data", cpu_rsp_data, 32'd0);
        chk("reset ram_req_valid", 32'(ram_req_valid), 32'd0);
        chk("reset ram_req_addr", ram_req_addr, 32'd0);
        chk("reset hit_count", 32'(hit_count), 32'd0);
        chk("reset miss_count", 32'(miss_count), 32'd0);
        rstn = 1'b1;
        step();
        chk("ready after reset", 32'(cpu_req_ready), 32'd1);

        // Cold miss
        run_vec(0);

        // Back-to-back hits, one response per cycle
        acc0 = ram_accepts;
        cpu_req_valid = 1'b1;
        cpu_req_addr = 32'h0000_010C;
        step();
        cpu_req_addr = 32'h0000_0100;
        chk("b2b first valid", 32'(cpu_rsp_valid), 32'd1);
        chk("b2b first data", cpu_rsp_data, 32'hDDDDDDDD);
        step();
        cpu_req_valid = 1'b0;
        chk("b2b second valid", 32'(cpu_rsp_valid), 32'd1);
        chk("b2b second data", cpu_rsp_data, 32'hAAAAAAAA);
        step();
        chk("b2b pulse ends", 32'(cpu_rsp_valid), 32'd0);
        chk("b2b hit_count", 32'(hit_count), 32'd2);
        chk("b2b no ram req", 32'(ram_accepts - acc0), 32'd0);

        // Conflict misses and further hits/misses
        for (int i = 1; i < 6; i++) run_vec(i);

        // RAM backpressure for three cycles
        acc0 = ram_accepts;
        cpu_req_valid = 1'b1;
        cpu_req_addr = 32'h0000_0204;
        step();
        cpu_req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp valid c%0d", i), 32'(ram_req_valid), 32'd1);
            chk($sformatf("bp addr c%0d", i), ram_req_addr, 32'h0000_0200);
            chk($sformatf("bp not ready c%0d", i), 32'(cpu_req_ready), 32'd0);
            step();
        end
        chk("bp valid at accept", 32'(ram_req_valid), 32'd1);
        ram_req_ready = 1'b1;
        step();
        chk("bp valid dropped", 32'(ram_req_valid), 32'd0);
        step();
        ram_req_ready = 1'b0;
        chk("bp one accept", 32'(ram_accepts - acc0), 32'd1);
        ram_rsp_valid = 1'b1;
        ram_rsp_data = L4;
        step();
        ram_rsp_valid = 1'b0;
        chk("bp rsp_valid", 32'(cpu_rsp_valid), 32'd1);
        chk("bp rsp_data", cpu_rsp_data, 32'hA1A1A1A1);
        step();
        chk("bp miss_count", 32'(miss_count), 32'd5);

        // Flush during WAIT: word still returned, line dropped afterwards
        cpu_req_valid = 1'b1;
        cpu_req_addr = 32'h0000_0304;
        step();
        cpu_req_valid = 1'b0;
        chk("fl ram_req_addr", ram_req_addr, 32'h0000_0300);
        ram_req_ready = 1'b1;
        step();
        ram_req_ready = 1'b0;
        chk("fl in WAIT", 32'(dbg_state), 32'd2);
        chk("fl ready in WAIT", 32'(cpu_req_ready), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        ram_rsp_valid = 1'b1;
        ram_rsp_data = L5;
        step();
        ram_rsp_valid = 1'b0;
        chk("fl rsp_valid", 32'(cpu_rsp_valid), 32'd1);
        chk("fl rsp_data", cpu_rsp_data, 32'h51515151);
        step();
        chk("fl idle ready held low", 32'(cpu_req_ready), 32'd0);
        chk("fl idle state", 32'(dbg_state), 32'd0);
        step();
        chk("fl ready restored", 32'(cpu_req_ready), 32'd1);
        do_req("fl refetch", 32'h0000_0304, L5, 1'b0, 32'h0000_0300, 32'h51515151);
        chk("fl miss_count", 32'(miss_count), 32'd7);

        // Flush and a hitting request together in IDLE: flush wins
        cpu_req_valid = 1'b1;
        cpu_req_addr = 32'h0000_0304;
        flush = 1'b1;
        #1;
        chk("flreq ready", 32'(cpu_req_ready), 32'd0);
        step();
        cpu_req_valid = 1'b0;
        flush = 1'b0;
        chk("flreq no rsp", 32'(cpu_rsp_valid), 32'd0);
        chk("flreq no ram req", 32'(ram_req_valid), 32'd0);
        chk("flreq hit_count", 32'(hit_count), 32'd4);
        do_req("flreq after", 32'h0000_0304, L5, 1'b0, 32'h0000_0300, 32'h51515151);
        chk("flreq miss_count", 32'(miss_count), 32'd8);

        // Reset while a miss sits in REQ
        cpu_req_valid = 1'b1;
        cpu_req_addr = 32'h0000_0404;
        step();
        cpu_req_valid = 1'b0;
        chk("rst in REQ", 32'(ram_req_valid), 32'd1);
        rstn = 1'b0;
        #1;
        chk("rst ram_req_valid", 32'(ram_req_valid), 32'd0);
        chk("rst hit_count", 32'(hit_count), 32'd0);
        chk("rst miss_count", 32'(miss_count), 32'd0);
        chk("rst state", 32'(dbg_state), 32'd0);
        step();
        rstn = 1'b1;
        ram_rsp_valid = 1'b1;
        ram_rsp_data = L1;
        step();
        ram_rsp_valid = 1'b0;
        chk("stale rsp ignored", 32'(cpu_rsp_valid), 32'd0);
        chk("stale rsp state", 32'(dbg_state), 32'd0);
        do_req("post-rst", 32'h0000_0104, L1, 1'b0, 32'h0000_0100, 32'hBBBBBBBB);
        chk("post-rst miss_count", 32'(miss_count), 32'd1);
        chk("post-rst hit_count", 32'(hit_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_line_buffer.md
Name: fetch_line_buffer

Overview:
Parametrised, direct-mapped line buffer between the CPUMIPS fetch/load port and line-wide RAM. It generalises the fixed 32-bit-address / 128-bit-line RAM hookup to configurable word width, line size and entry count. RAM requests and responses use valid/ready handshakes. Hits return a word one cycle after acceptance; misses fetch a whole line, fill an entry, then return the word.

Parameters:
ADDR_W, 32, byte-address width.
WORD_W, 32, CPU word width in bits; multiple of 8.
LINE_WORDS, 4, words per line; power of 2, >=2.
ENTRIES, 4, buffer entries; power of 2, >=1.
Derived: BO=log2(WORD_W/8), WO=log2(LINE_WORDS), IX=log2(ENTRIES), TAG_W=ADDR_W-BO-WO-IX.

Ports:
clk  in  1  clock, rising edge.
rstn  in  1  reset; asynchronous, active-low.
cpu_req_valid  in  1  CPU read request.
cpu_req_addr  in  ADDR_W  byte address; low BO bits ignored.
cpu_req_ready  out  1  block can accept a request.
cpu_rsp_valid  out  1  one-cycle pulse; cpu_rsp_data is valid.
cpu_rsp_data  out  WORD_W  requested word.
flush  in  1  invalidate all entries.
ram_req_valid  out  1  line request to RAM.
ram_req_addr  out  ADDR_W  line-aligned address; low BO+WO bits are 0.
ram_req_ready  in  1  RAM accepts the request.
ram_rsp_valid  in  1  line data valid.
ram_rsp_data  in  WORD_W*LINE_WORDS  line data; word 0 in the LSBs.
hit_count  out  16  saturating hit counter.
miss_count  out  16  saturating miss counter.

Behaviour:
- Address split: word offset = addr[BO+WO-1:BO]; index = next IX bits; tag = the remaining upper bits.
- Reset, asynchronous on rstn=0:
  - all valid bits cleared; state=IDLE.
  - cpu_rsp_valid=0, cpu_rsp_data=0, ram_req_valid=0, ram_req_addr=0.
  - hit_count=0, miss_count=0, flush_pending=0.
  - Data/tag arrays are not reset.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - cpu_req_ready = !flush && !flush_pending.
  - Acceptance happens on cpu_req_valid && cpu_req_ready at edge T.
  - Hit (valid[idx] && tag match): stay in IDLE; cpu_rsp_valid=1 with the selected word at T+1; hit_count++.
  - Back-to-back hits: one response per cycle.
  - Miss: latch addr; miss_count++; go to REQ.
- REQ:
  - ram_req_valid=1; ram_req_addr = latched addr with low BO+WO bits zeroed.
  - Both outputs held stable until ram_req_ready=1, then go to WAIT.
  - Earliest ram_req_valid is T+1.
- WAIT:
  - On ram_rsp_valid: write the line, the tag and valid[idx]=1; go to RESP.
  - ram_rsp_valid is ignored in every other state.
- RESP:
  - cpu_rsp_valid=1 for one cycle, carrying the word taken from the filled line; then IDLE.
  - Miss latency: response cycle R+1, where R is the ram_rsp_valid cycle.
- cpu_req_ready=0 in REQ, WAIT and RESP.
- flush:
  - In IDLE with flush=1: all valid bits cleared next edge; no request accepted that cycle.
  - If flush is asserted in REQ, WAIT or RESP: set flush_pending. The in-flight miss completes and its word is still returned. On return to IDLE all valids clear (including the line just filled), flush_pending clears, and cpu_req_ready stays 0 for that cycle.
- Simultaneous hit and flush in IDLE: flush wins; the request is not accepted.
- Counters saturate at 16'hFFFF and never wrap.
- Reset mid-miss: immediate return to IDLE; ram_req_valid drops. The RAM side must be reset together; a stale ram_rsp_valid arriving in IDLE is ignored.
- cpu_req_addr is sampled only at acceptance; later changes have no effect.

Test Plan (WORD_W=32, LINE_WORDS=4, ENTRIES=4):
1. Cold miss: request 0x0000_0104.
   - Required: ram_req_addr=0x0000_0100.
   - RAM returns 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA → cpu_rsp_data=0xBBBBBBBB one cycle after ram_rsp_valid.
   - miss_count=1.
2. Hits after scenario 1: back-to-back requests 0x10C and 0x100.
   - Required: 0xDDDDDDDD and 0xAAAAAAAA on consecutive cycles.
   - No ram_req_valid; hit_count=2.
3. Conflict: request 0x140 (same index 0, different tag).
   - Required: miss and new RAM request at 0x140.
   - Then request 0x104 → miss again; miss_count=3.
4. RAM backpressure: ram_req_ready held 0 for 3 cycles.
   - Required: ram_req_valid and ram_req_addr stable all 3 cycles.
   - Exactly one request is accepted.
5. Flush:
   - Pulse flush during WAIT → that word is still returned; a following request to the same line misses.
   - Flush and a request together in IDLE → cpu_req_ready=0; request not accepted.
6. Reset in REQ (rstn low for 1 cycle):
   - Required: ram_req_valid=0 and counters=0 immediately.
   - The next request to 0x104 misses.
